// File: rtl/cnu_msg_gen.sv
// Min-sum check-node output stage. Takes the min / min2 / min_idx summary
// and the sign bits of one row, applies the offset correction and
// regenerates the D check-to-variable messages one per cycle. A 2-entry
// row buffer lets the next row be captured while the current one drains.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready and out_valid depend only on registered
// state. Once out_valid is high, out_* hold stable until out_ready is seen.
module cnu_msg_gen #(
   parameter int data_w = 9,
   parameter int idx_w  = 3,
   parameter int D      = 7,
   parameter int OFFSET = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [data_w-1:0] min,
   input  logic [data_w-1:0] min2,
   input  logic [idx_w-1:0]  min_idx,
   input  logic [D-1:0]      signs,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [data_w-1:0] out_mag,
   output logic [idx_w-1:0]  out_idx,
   output logic              out_last
);

   localparam logic [data_w-1:0] L_OFF  = data_w'(OFFSET);
   localparam logic [idx_w-1:0]  L_LAST = idx_w'(D - 1);

   // Row buffer payload, one slot per entry.
   logic [data_w-1:0] r_m1    [2];
   logic [data_w-1:0] r_m2    [2];
   logic [idx_w-1:0]  r_idx   [2];
   logic [D-1:0]      r_signs [2];
   logic              r_tsign [2];

   // Buffer bookkeeping and edge counter of the head row.
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic [idx_w-1:0]  r_k;

   logic              w_push;
   logic              w_hs;
   logic              w_k_last;
   logic              w_pop;
   logic [data_w-1:0] w_m1;
   logic [data_w-1:0] w_m2;

   // Offset correction, saturating at zero.
   always_comb begin
      w_m1 = (min  > L_OFF) ? (min  - L_OFF) : '0;
      w_m2 = (min2 > L_OFF) ? (min2 - L_OFF) : '0;
   end

   // Handshake decode; everything here derives from registered state.
   always_comb begin
      in_ready  = (r_count != 2'd2);
      out_valid = (r_count != 2'd0);
      w_push    = in_valid && in_ready;
      w_hs      = out_valid && out_ready;
      w_k_last  = (r_k == L_LAST);
      w_pop     = w_hs && w_k_last;
   end

   // Message regeneration from the head entry. An out-of-range min_idx
   // never matches r_k, so every edge then gets m1.
   always_comb begin
      out_mag  = (r_k == r_idx[r_rd_ptr]) ? r_m2[r_rd_ptr] : r_m1[r_rd_ptr];
      out_sign = r_tsign[r_rd_ptr] ^ r_signs[r_rd_ptr][r_k];
      out_idx  = r_k;
      out_last = w_k_last;
   end

   // Capture a row summary into the write slot.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_m1[r_wr_ptr]    <= w_m1;
         r_m2[r_wr_ptr]    <= w_m2;
         r_idx[r_wr_ptr]   <= min_idx;
         r_signs[r_wr_ptr] <= signs;
         r_tsign[r_wr_ptr] <= ^signs;
      end
   end

   // Pointers, occupancy and edge counter; reset discards all buffered rows.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_k      <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         if (w_push && !w_pop)      r_count <= r_count + 2'd1;
         else if (!w_push && w_pop) r_count <= r_count - 2'd1;
         if (w_hs) r_k <= w_k_last ? '0 : r_k + idx_w'(1);
      end
   end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Bench for cnu_msg_gen: directed rows from the test plan followed by
// random rows under random backpressure, all checked against a
// message-queue model of the expected output stream.
module tb_cnu_msg_gen;

   localparam int DW  = 9;
   localparam int IW  = 3;
   localparam int DD  = 7;
   localparam int OFF = 1;
   localparam int MW  = 1 + DW + IW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] min = '0;
   logic [DW-1:0] min2 = '0;
   logic [IW-1:0] min_idx = '0;
   logic [DD-1:0] signs = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sign;
   logic [DW-1:0] out_mag;
   logic [IW-1:0] out_idx;
   logic          out_last;

   int n_checks = 0;
   int n_pass   = 0;
   int hs_cnt   = 0;
   int last_cnt = 0;
   int rdy_mode = 0;
   bit model_on = 0;

   // Expected messages {sign, mag, idx, last}, oldest first.
   logic [MW-1:0] exp_q[$];

   cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(DD), .OFFSET(OFF)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .min(min), .min2(min2), .min_idx(min_idx), .signs(signs),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_mag(out_mag), .out_idx(out_idx), .out_last(out_last)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      else n_pass++;
   endtask

   // Message k of a row: magnitude is the smallest of the other edges
   // (offset corrected), sign is the parity of the other edges' signs.
   function automatic logic [MW-1:0] msg_of(input int mn, input int mn2, input int ix,
                                            input logic [DD-1:0] sg, input int k);
      int m1, m2, mag, par;
      m1  = (mn  > OFF) ? mn  - OFF : 0;
      m2  = (mn2 > OFF) ? mn2 - OFF : 0;
      mag = (k == ix) ? m2 : m1;
      par = ($countones(sg) - int'(sg[k])) % 2;
      return {par[0], mag[DW-1:0], k[IW-1:0], (k == DD - 1)};
   endfunction

   // Model + compare, once per cycle on the falling edge.
   initial begin
      bit rdy_e;
      forever begin
         @(negedge clk);
         if (model_on) begin
            chk("in_ready", in_ready, exp_q.size() <= DD);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("msg", {out_sign, out_mag, out_idx, out_last}, exp_q[0]);
            else chk("out_last_idle", out_last, 0);
         end
         if (rst) begin
            exp_q.delete();
            model_on = 1;
         end else if (model_on) begin
            rdy_e = (exp_q.size() <= DD);
            if (exp_q.size() != 0 && out_ready) begin
               hs_cnt++;
               if (exp_q[0][0]) last_cnt++;
               void'(exp_q.pop_front());
            end
            if (in_valid && rdy_e)
               for (int k = 0; k < DD; k++) exp_q.push_back(msg_of(min, min2, min_idx, signs, k));
         end
      end
   end

   // out_ready driver for the patterned / random modes.
   initial begin
      int p = 0;
      forever begin
         @(posedge clk); #1;
         p++;
         if (rdy_mode == 2) out_ready = $urandom_range(0, 1);
         else if (rdy_mode == 3) out_ready = (p % 3 == 0);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_rdy(input int mode);
      rdy_mode  = mode;
      out_ready = (mode != 1);
   endtask

   // Present a row until accepted; returns one step after the accepting edge.
   task automatic send_row(input int mn, input int mn2, input int ix, input logic [DD-1:0] sg);
      bit done = 0;
      in_valid = 1'b1; min = mn[DW-1:0]; min2 = mn2[DW-1:0]; min_idx = ix[IW-1:0]; signs = sg;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         tick();
      end
      if (!done) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      bit done = 0;
      for (int t = 0; t < 2000 && !done; t++) begin
         tick();
         if (exp_q.size() == 0) done = 1;
      end
      if (!done) chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int h0, l0;
      // Pin the model with hand-computed messages.
      chk("model_basic_k0", msg_of(5, 9, 2, 7'b0000001, 0), {1'b0, 9'd4, 3'd0, 1'b0});
      chk("model_basic_k2", msg_of(5, 9, 2, 7'b0000001, 2), {1'b1, 9'd8, 3'd2, 1'b0});
      chk("model_basic_k6", msg_of(5, 9, 2, 7'b0000001, 6), {1'b1, 9'd4, 3'd6, 1'b1});
      chk("model_sat_zero", msg_of(0, 1, 0, 7'b0000000, 0), {1'b0, 9'd0, 3'd0, 1'b0});
      chk("model_sat_top",  msg_of(511, 511, 0, 7'b0, 3), {1'b0, 9'd510, 3'd3, 1'b0});
      chk("model_oor",      msg_of(3, 6, 7, 7'b0, 5), {1'b0, 9'd2, 3'd5, 1'b0});

      // Reset
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
      tick();

      // Basic row and first-cycle latency.
      set_rdy(0);
      send_row(5, 9, 2, 7'b0000001);
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_idx", out_idx, 0);
      chk("lat_out_mag", out_mag, 4);
      chk("lat_out_sign", out_sign, 0);
      wait_empty();

      // Saturation at both ends.
      send_row(0, 1, 0, 7'b0);
      send_row(511, 511, 3, 7'b1100101);
      wait_empty();

      // Backpressure 1,0,0,...
      set_rdy(3);
      h0 = hs_cnt; l0 = last_cnt;
      send_row(5, 9, 2, 7'b0000001);
      wait_empty();
      chk("bp_handshakes", hs_cnt - h0, 7);
      chk("bp_last", last_cnt - l0, 1);

      // Buffer full, third row held off.
      set_rdy(1);
      send_row(10, 12, 1, 7'b0110011);
      send_row(20, 40, 5, 7'b1000000);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      tick();
      in_valid = 1'b1; min = 9'd100; min2 = 9'd200; min_idx = 3'd0; signs = 7'b1111111;
      repeat (3) tick();
      in_valid = 1'b0;
      set_rdy(0);
      wait_empty();

      // Out-of-range min_idx.
      send_row(3, 6, 7, 7'b0101010);
      wait_empty();

      // Reset mid-row with a second row buffered.
      h0 = hs_cnt;
      send_row(30, 31, 1, 7'b0011001);
      send_row(40, 50, 2, 7'b1110000);
      for (int t = 0; t < 50 && (hs_cnt - h0) < 3; t++) tick();
      chk("mid_handshakes", hs_cnt - h0, 3);
      rst = 1'b1; in_valid = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_in_ready", in_ready, 1);
      tick();
      send_row(7, 20, 4, 7'b1010101);
      @(negedge clk);
      chk("new_out_idx", out_idx, 0);
      chk("new_out_mag", out_mag, 6);
      chk("new_out_sign", out_sign, 1);
      wait_empty();

      // Random rows under random backpressure.
      set_rdy(2);
      for (int r = 0; r < 40; r++) begin
         int mn;
         mn = $urandom_range(0, 511);
         send_row(mn, $urandom_range(mn, 511), $urandom_range(0, 7), 7'($urandom_range(0, 127)));
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_empty();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cnu_msg_gen.md
# cnu_msg_gen

Check-node output stage of the min-sum CNU: consumes the registered min / min2 / min_idx result of the comparison tree, together with the sign bits of the same D incoming messages, and regenerates the D check-to-variable messages one per cycle. Applies offset min-sum correction and carries a 2-entry row buffer, so the next row can be captured while the current one drains to the downstream variable-node path under valid/ready flow control.

## Interface
- data_w, 9, magnitude width; matches the comparison tree.
- idx_w, 3, index width; must satisfy 2^idx_w > D.
- D, 7, check-node degree (messages per row).
- OFFSET, 1, offset subtracted from min and min2 magnitudes (unsigned, < 2^data_w).

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  row summary valid.
- in_ready  out  1  row buffer can accept.
- min  in  data_w  smallest input magnitude.
- min2  in  data_w  second-smallest input magnitude.
- min_idx  in  idx_w  position of min.
- signs  in  D  sign bit of each input message, bit k = message k.
- out_valid  out  1  out_* hold a message.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  sign of message k (1 = negative).
- out_mag  out  data_w  magnitude of message k.
- out_idx  out  idx_w  edge index k, 0..D-1.
- out_last  out  1  high when out_idx == D-1.

## Operation
- Row capture on in_valid && in_ready: compute and store in the write entry:
  - m1 = (min > OFFSET) ? min - OFFSET : 0; m2 = (min2 > OFFSET) ? min2 - OFFSET : 0 (saturate at 0, width data_w).
  - min_idx, signs, and tsign = XOR of all D bits of signs.
- Buffer: 2 entries, write pointer, read pointer, count 0..2. in_ready = (count < 2); no combinational path from out_ready to in_ready.
- Emission from the head entry, edge counter k (0..D-1):
  - out_mag = (k == min_idx) ? m2 : m1; if min_idx >= D, every edge uses m1.
  - out_sign = tsign ^ signs[k]; out_idx = k; out_last = (k == D-1).
  - out_valid = (count != 0). All out_* are functions of registered state only.
- On out_valid && out_ready: k increments; if k == D-1: k <= 0, pop head (read pointer advances).
- Simultaneous capture and pop in the same cycle: count unchanged, both pointers advance; legal at count 1. At count 2, in_ready is 0, so no capture occurs.
- min2 >= min is guaranteed by the producer; not checked.

## Timing
- Reset (rst high at a clock edge): count = 0, pointers = 0, k = 0. Next cycle: out_valid = 0, out_last = 0, in_ready = 1. Inputs are ignored while rst is high.
- Reset mid-row: the partially emitted row and any buffered row are discarded. No further messages from that row appear.
- Latency: row accepted at edge N gives out_valid = 1 in cycle N+1, with k = 0, if the buffer was empty.
- Throughput: one message per cycle while out_ready = 1, so one row per D cycles. Back-to-back rows emit with no bubble.
- When out_valid = 1 and out_ready = 0, all out_* hold stable until the handshake.

## Test plan
(D=7, data_w=9, OFFSET=1)
- Basic row: min=5, min2=9, min_idx=2, signs=7'b0000001, out_ready=1 -> 7 consecutive messages k=0..6. k=0: sign 0, mag 4. k=2: sign 1, mag 8. Other k: sign 1, mag 4. out_last only at k=6. First out_valid one cycle after accept.
- Saturation: min=0, min2=1, min_idx=0, signs=0 -> all mags 0, all signs 0. Then min=511, min2=511 -> mags 510.
- Backpressure: basic row with out_ready toggling 1,0,0,1,... -> out_* stable during stalls. Exactly 7 handshakes. out_last on the 7th handshake only.
- Buffer full: two rows on consecutive cycles with out_ready=0 -> both accepted, in_ready=0 afterwards, and a third in_valid is held. Raise out_ready -> row 1 emitted, then row 2 with no gap. in_ready returns to 1 on the cycle after row 1's last handshake.
- Out-of-range index: min=3, min2=6, min_idx=7 -> all 7 mags = 2.
- Reset mid-row: rst for 1 cycle after 3 handshakes, with a second row buffered -> out_valid=0 and in_ready=1 on the next cycle. A new row then starts at out_idx=0 with its own values.
